alu_control_unit: RTL and testbench
===================================

# alu_control_unit

Registered ALU control decoder for the pipelined MIPS core. Combines the 2-bit `alu_op` class from the main control unit with the 6-bit R-type `funct` field to produce the 3-bit ALU operation select. It sits in the ID/EX path, and its output is registered one clock after the inputs are presented.

## Interface
- No parameters. Widths are fixed by the ISA.
- One clock; reset is asynchronous and active-high.
- `clk` input 1: rising-edge clock.
- `reset` input 1: asynchronous, active-high reset.
- `inst` input 6: instruction `funct` field (bits [5:0]).
- `alu_op` input 2: operation class from the main control unit.
- `sel` output 3: registered ALU operation select.
- `illegal` output 1: registered flag. High when the funct/alu_op combination is unsupported.

## Operation
- `alu_op` class decode:
  - 2'b00 (load/store/ADDI): sel=3'b010 (add). `inst` is ignored.
  - 2'b01 (branch): sel=3'b110 (subtract). `inst` is ignored.
  - 2'b10 (R-type): decode `inst` as listed below.
  - 2'b11 (reserved): sel=3'b010, illegal=1.
- R-type funct decode (alu_op=2'b10):
  - ADD 6'b100000 → 3'b010
  - ADDU 6'b100001 → 3'b100
  - SUB 6'b100010 → 3'b110
  - SUBU 6'b100011 → 3'b110
  - AND 6'b100100 → 3'b000
  - OR 6'b100101 → 3'b001
  - SLL 6'b000000 → 3'b101
  - SLT 6'b101010 → 3'b011
  - SLTU 6'b101011 → 3'b111
  - Any other funct → sel=3'b010, illegal=1.
- `illegal` is 0 for every listed funct and for alu_op 00/01.
- The decode is a full case with no latches. X/Z on inputs must not be masked; propagate per normal RTL semantics.

## Timing
- Decode is combinational. `sel` and `illegal` are captured on the rising edge of `clk`.
- Latency is 1 cycle: inputs stable before edge N appear on the outputs after edge N.
- Reset values: sel=3'b010, illegal=0. Reset asserts immediately, independent of the clock.
- An input change mid-cycle has no effect on the outputs until the next rising edge.
- Reset deasserted coincident with a clock edge: that edge does not load; the first load is on the following edge.
- Back-to-back differing inputs update every cycle, with no holding or throttling.
- There is no enable; the register loads every cycle.

## Structure
- Shared package `alu_ctrl_pkg` holds:
  - `ALU_AND=3'b000`, `ALU_OR=3'b001`, `ALU_ADD=3'b010`, `ALU_SLT=3'b011`, `ALU_ADDU=3'b100`, `ALU_SLL=3'b101`, `ALU_SUB=3'b110`, `ALU_SLTU=3'b111`.
  - `ALUOP_MEM=2'b00`, `ALUOP_BR=2'b01`, `ALUOP_RTYPE=2'b10`, `ALUOP_RSVD=2'b11`.
  - `FUNCT_*` constants for the nine supported funct codes.
- One natural combinational sub-module, `alu_funct_decode`: funct → {sel, illegal}.
- The top level instantiates `alu_funct_decode`, muxes on `alu_op`, and holds the output register.

## Test plan
- Reset: assert `reset` with no clock → sel=3'b010, illegal=0 immediately. Hold inputs (alu_op=2'b10, inst=6'b100100) with reset high across edges → outputs stay at 3'b010/0.
- R-type sweep, alu_op=2'b10, one funct per cycle. Each result appears one edge later with illegal=0:
  - 100000 → 010, 100001 → 100, 100010 → 110, 100011 → 110, 100100 → 000
  - 100101 → 001, 000000 → 101, 101010 → 011, 101011 → 111
- Class override:
  - alu_op=2'b00, inst=6'b101011 → sel=3'b010, illegal=0.
  - alu_op=2'b01, inst=6'b100101 → sel=3'b110, illegal=0.
- Illegal decode:
  - alu_op=2'b10, inst=6'b111111 → sel=3'b010, illegal=1.
  - alu_op=2'b11, inst=6'b100000 → sel=3'b010, illegal=1.
  - Next cycle alu_op=2'b10, inst=6'b100100 → sel=3'b000, illegal=0.
- Latency: change `inst` mid-cycle from 6'b100010 to 6'b100101 → sel holds its prior value until the next rising edge, then becomes 3'b001.
- Async reset mid-operation: sel=3'b111, assert `reset` between edges → sel=3'b010 immediately. Release and clock with alu_op=2'b01 → sel=3'b110 after one edge.

Source files
------------

// File: rtl/alu_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module   : alu_ctrl_pkg
// Purpose  : Shared encodings for the ALU control decoder.
//            - ALU_*   : 3-bit ALU operation select codes
//            - ALUOP_* : 2-bit operation class from the main control unit
//            - FUNCT_* : supported R-type funct field codes
// Revision : 1.0  initial release
// ============================================================================
package alu_ctrl_pkg;

    localparam logic [2:0] ALU_AND  = 3'b000;
    localparam logic [2:0] ALU_OR   = 3'b001;
    localparam logic [2:0] ALU_ADD  = 3'b010;
    localparam logic [2:0] ALU_SLT  = 3'b011;
    localparam logic [2:0] ALU_ADDU = 3'b100;
    localparam logic [2:0] ALU_SLL  = 3'b101;
    localparam logic [2:0] ALU_SUB  = 3'b110;
    localparam logic [2:0] ALU_SLTU = 3'b111;

    localparam logic [1:0] ALUOP_MEM   = 2'b00;
    localparam logic [1:0] ALUOP_BR    = 2'b01;
    localparam logic [1:0] ALUOP_RTYPE = 2'b10;
    localparam logic [1:0] ALUOP_RSVD  = 2'b11;

    localparam logic [5:0] FUNCT_ADD  = 6'b100000;
    localparam logic [5:0] FUNCT_ADDU = 6'b100001;
    localparam logic [5:0] FUNCT_SUB  = 6'b100010;
    localparam logic [5:0] FUNCT_SUBU = 6'b100011;
    localparam logic [5:0] FUNCT_AND  = 6'b100100;
    localparam logic [5:0] FUNCT_OR   = 6'b100101;
    localparam logic [5:0] FUNCT_SLL  = 6'b000000;
    localparam logic [5:0] FUNCT_SLT  = 6'b101010;
    localparam logic [5:0] FUNCT_SLTU = 6'b101011;

endpackage : alu_ctrl_pkg
`default_nettype wire

// File: rtl/alu_funct_decode.sv
`default_nettype none
// ============================================================================
// Module   : alu_funct_decode
// Purpose  : Combinational R-type funct decoder.
// Ports    : i_funct   [5:0] in  - instruction funct field
//            o_sel     [2:0] out - ALU operation select
//            o_illegal       out - funct code is not supported
// Revision : 1.0  initial release
// ============================================================================
module alu_funct_decode
    import alu_ctrl_pkg::*;
(
    input  logic [5:0] i_funct,
    output logic [2:0] o_sel,
    output logic       o_illegal
);

    always_comb begin
        o_sel     = ALU_ADD;
        o_illegal = 1'b0;
        case (i_funct)
            FUNCT_ADD:  o_sel = ALU_ADD;
            FUNCT_ADDU: o_sel = ALU_ADDU;
            FUNCT_SUB:  o_sel = ALU_SUB;
            FUNCT_SUBU: o_sel = ALU_SUB;   // unsigned subtract shares the subtractor
            FUNCT_AND:  o_sel = ALU_AND;
            FUNCT_OR:   o_sel = ALU_OR;
            FUNCT_SLL:  o_sel = ALU_SLL;
            FUNCT_SLT:  o_sel = ALU_SLT;
            FUNCT_SLTU: o_sel = ALU_SLTU;
            default: begin
                // Unsupported funct falls back to add and raises the flag
                o_sel     = ALU_ADD;
                o_illegal = 1'b1;
            end
        endcase
    end

endmodule : alu_funct_decode
`default_nettype wire

// File: rtl/alu_control_unit.sv
`default_nettype none
// ============================================================================
// Module   : alu_control_unit
// Purpose  : Registered ALU control decoder for the ID/EX path. Combines the
//            alu_op class with the R-type funct field and registers the
//            resulting ALU select one clock after the inputs are presented.
// Ports    : clk          in  - rising-edge clock
//            reset        in  - asynchronous active-high reset
//            inst   [5:0] in  - instruction funct field
//            alu_op [1:0] in  - operation class from main control
//            sel    [2:0] out - registered ALU operation select
//            illegal      out - registered unsupported-combination flag
// Revision : 1.0  initial release
// ============================================================================
module alu_control_unit
    import alu_ctrl_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] inst,
    input  logic [1:0] alu_op,
    output logic [2:0] sel,
    output logic       illegal
);

    logic [2:0] w_funct_sel;
    logic       w_funct_illegal;
    logic [2:0] w_next_sel;
    logic       w_next_illegal;
    logic [2:0] r_sel;
    logic       r_illegal;

    alu_funct_decode u_funct_decode (
        .i_funct   (inst),
        .o_sel     (w_funct_sel),
        .o_illegal (w_funct_illegal)
    );

    // Class mux: only R-type consults the funct decoder
    always_comb begin
        w_next_sel     = ALU_ADD;
        w_next_illegal = 1'b0;
        case (alu_op)
            ALUOP_MEM:   w_next_sel = ALU_ADD;
            ALUOP_BR:    w_next_sel = ALU_SUB;
            ALUOP_RTYPE: begin
                w_next_sel     = w_funct_sel;
                w_next_illegal = w_funct_illegal;
            end
            ALUOP_RSVD: begin
                w_next_sel     = ALU_ADD;
                w_next_illegal = 1'b1;
            end
            default: begin
                w_next_sel     = ALU_ADD;
                w_next_illegal = 1'b1;
            end
        endcase
    end

    // Output register loads every cycle; no enable
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_sel     <= ALU_ADD;
            r_illegal <= 1'b0;
        end else begin
            r_sel     <= w_next_sel;
            r_illegal <= w_next_illegal;
        end
    end

    assign sel     = r_sel;
    assign illegal = r_illegal;

endmodule : alu_control_unit
`default_nettype wire

// File: tb/tb_alu_control_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_alu_control_unit
// Purpose  : Self-checking bench for alu_control_unit: directed vector table,
//            hand-written timing sequences and randomized traffic against a
//            lookup-table reference model.
// Revision : 1.0  initial release
// ============================================================================
module tb_alu_control_unit;

    logic       clk = 1'b0;
    logic       reset;
    logic [5:0] inst;
    logic [1:0] alu_op;
    logic [2:0] sel;
    logic       illegal;

    int pass_cnt  = 0;
    int total_cnt = 0;

    always #5 clk = ~clk;

    alu_control_unit dut (
        .clk     (clk),
        .reset   (reset),
        .inst    (inst),
        .alu_op  (alu_op),
        .sel     (sel),
        .illegal (illegal)
    );

    typedef struct {
        logic [1:0] op;
        logic [5:0] funct;
        logic [2:0] exp_sel;
        logic       exp_ill;
    } vec_t;

    vec_t vecs[15];

    // Reference model: a 64-entry table of {sel, illegal} for R-type
    logic [3:0] rtype_map [64];
    logic [5:0] legal_funct [9];

    function automatic logic [3:0] ref_model(input logic [1:0] op, input logic [5:0] f);
        case (op)
            2'b00:   return {3'b010, 1'b0};
            2'b01:   return {3'b110, 1'b0};
            2'b10:   return rtype_map[f];
            default: return {3'b010, 1'b1};
        endcase
    endfunction

    task automatic check(input string name, input logic [2:0] exp_sel, input logic exp_ill);
        total_cnt++;
        if (sel === exp_sel && illegal === exp_ill)
            pass_cnt++;
        else
            $display("FAIL %s: got sel=%b illegal=%b, required sel=%b illegal=%b",
                     name, sel, illegal, exp_sel, exp_ill);
    endtask

    task automatic apply(input logic [1:0] op, input logic [5:0] f);
        @(negedge clk);
        alu_op = op;
        inst   = f;
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [3:0] e;
        logic [5:0] f;
        logic [1:0] op;

        for (int i = 0; i < 64; i++) rtype_map[i] = {3'b010, 1'b1};
        rtype_map[6'b100000] = {3'b010, 1'b0};
        rtype_map[6'b100001] = {3'b100, 1'b0};
        rtype_map[6'b100010] = {3'b110, 1'b0};
        rtype_map[6'b100011] = {3'b110, 1'b0};
        rtype_map[6'b100100] = {3'b000, 1'b0};
        rtype_map[6'b100101] = {3'b001, 1'b0};
        rtype_map[6'b000000] = {3'b101, 1'b0};
        rtype_map[6'b101010] = {3'b011, 1'b0};
        rtype_map[6'b101011] = {3'b111, 1'b0};
        legal_funct = '{6'b100000, 6'b100001, 6'b100010, 6'b100011, 6'b100100,
                        6'b100101, 6'b000000, 6'b101010, 6'b101011};

        vecs[0]  = '{2'b10, 6'b100000, 3'b010, 1'b0};
        vecs[1]  = '{2'b10, 6'b100001, 3'b100, 1'b0};
        vecs[2]  = '{2'b10, 6'b100010, 3'b110, 1'b0};
        vecs[3]  = '{2'b10, 6'b100011, 3'b110, 1'b0};
        vecs[4]  = '{2'b10, 6'b100100, 3'b000, 1'b0};
        vecs[5]  = '{2'b10, 6'b100101, 3'b001, 1'b0};
        vecs[6]  = '{2'b10, 6'b000000, 3'b101, 1'b0};
        vecs[7]  = '{2'b10, 6'b101010, 3'b011, 1'b0};
        vecs[8]  = '{2'b10, 6'b101011, 3'b111, 1'b0};
        vecs[9]  = '{2'b00, 6'b101011, 3'b010, 1'b0};
        vecs[10] = '{2'b01, 6'b100101, 3'b110, 1'b0};
        vecs[11] = '{2'b10, 6'b111111, 3'b010, 1'b1};
        vecs[12] = '{2'b11, 6'b100000, 3'b010, 1'b1};
        vecs[13] = '{2'b10, 6'b100100, 3'b000, 1'b0};
        vecs[14] = '{2'b10, 6'b000001, 3'b010, 1'b1};

        // Reset with no clock edge yet
        reset  = 1'b1;
        alu_op = 2'b10;
        inst   = 6'b100100;
        #2;
        check("reset_no_clock", 3'b010, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        check("reset_held_edges", 3'b010, 1'b0);
        @(negedge clk);
        reset = 1'b0;

        // Directed table
        for (int i = 0; i < 15; i++) begin
            apply(vecs[i].op, vecs[i].funct);
            check($sformatf("vec%0d", i), vecs[i].exp_sel, vecs[i].exp_ill);
        end

        // Mid-cycle input change is invisible until the next edge
        apply(2'b10, 6'b100010);
        check("latency_pre", 3'b110, 1'b0);
        #2 inst = 6'b100101;
        #1;
        check("latency_hold", 3'b110, 1'b0);
        @(posedge clk);
        #1;
        check("latency_update", 3'b001, 1'b0);

        // Asynchronous reset between edges
        apply(2'b10, 6'b101011);
        check("async_pre", 3'b111, 1'b0);
        #2 reset = 1'b1;
        #1;
        check("async_reset_now", 3'b010, 1'b0);
        @(negedge clk);
        reset  = 1'b0;
        alu_op = 2'b01;
        @(posedge clk);
        #1;
        check("after_reset_branch", 3'b110, 1'b0);

        // Randomized traffic, biased toward legal funct codes
        for (int n = 0; n < 300; n++) begin
            op = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 1) == 0)
                f = legal_funct[$urandom_range(0, 8)];
            else
                f = 6'($urandom);
            e = ref_model(op, f);
            apply(op, f);
            check($sformatf("rand%0d op=%b f=%b", n, op, f), e[3:1], e[0]);
        end

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule : tb_alu_control_unit
`default_nettype wire
